regfile_operand_fetch: RTL and testbench

REGFILE_OPERAND_FETCH -- requirements
Module: regfile_operand_fetch

---
 rtl/regfile_operand_fetch_pkg.sv | 14 +
 rtl/regfile_bypass.sv | 29 ++
 rtl/regfile_operand_fetch.sv | 171 +++++++++++++++++
 tb/tb_regfile_operand_fetch.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_operand_fetch_pkg.sv
// Shared types for the operand fetch stage: the slot state encoding that is
// also exported on the debug port.
package regfile_operand_fetch_pkg;

  // IDLE : slot empty
  // FIRST: first valid cycle, operands come from bypass capture or read data
  // HOLD : later valid cycles, operands come from the hold registers
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FIRST = 2'd1,
    ST_HOLD  = 2'd2
  } slot_state_e;

endpackage

// File: rtl/regfile_bypass.sv
// Write-port snoop for one source operand: compares the operand address with
// both register file write ports. Port b has priority, x0 never hits.
module regfile_bypass #(
  parameter int C_XLEN = 32,
  localparam int REG_AW = 5
) (
  input  logic [REG_AW-1:0] addr_i,
  input  logic              wr_a_i,
  input  logic [REG_AW-1:0] waddr_a_i,
  input  logic [C_XLEN-1:0] wdata_a_i,
  input  logic              wr_b_i,
  input  logic [REG_AW-1:0] waddr_b_i,
  input  logic [C_XLEN-1:0] wdata_b_i,
  output logic              hit_o,
  output logic [C_XLEN-1:0] data_o
);

  logic hit_a;
  logic hit_b;

  // Address match per port; b data wins when both ports write the same register.
  always_comb begin
    hit_a  = wr_a_i && (waddr_a_i == addr_i);
    hit_b  = wr_b_i && (waddr_b_i == addr_i);
    hit_o  = (addr_i != '0) && (hit_a || hit_b);
    data_o = hit_b ? wdata_b_i : wdata_a_i;
  end

endmodule

// File: rtl/regfile_operand_fetch.sv
// Operand fetch stage: single-slot buffer between issue and execute. Issues
// register file reads on accept, corrects read data with snooped writes, and
// keeps held operands coherent with writes while stalled.
//
// Handshake: a transfer happens on a cycle where valid and ready are both high
// at the rising edge (and clk_en_i is high). valid never depends on ready of
// the same interface; once exs_valid_o is high it stays high with stable
// operand meaning until the transfer completes.
module regfile_operand_fetch
  import regfile_operand_fetch_pkg::*;
#(
  parameter int C_XLEN = 32,
  localparam int REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              resetb_i,
  input  logic              clk_en_i,
  input  logic              ids_valid_i,
  output logic              ids_ready_o,
  input  logic              ids_rs1_rd_i,
  input  logic              ids_rs2_rd_i,
  input  logic [REG_AW-1:0] ids_rs1_addr_i,
  input  logic [REG_AW-1:0] ids_rs2_addr_i,
  output logic              rreg_a_rd_o,
  output logic              rreg_b_rd_o,
  output logic [REG_AW-1:0] rreg_a_addr_o,
  output logic [REG_AW-1:0] rreg_b_addr_o,
  input  logic [C_XLEN-1:0] rreg_a_data_i,
  input  logic [C_XLEN-1:0] rreg_b_data_i,
  input  logic              wreg_a_wr_i,
  input  logic [REG_AW-1:0] wreg_a_addr_i,
  input  logic [C_XLEN-1:0] wreg_a_data_i,
  input  logic              wreg_b_wr_i,
  input  logic [REG_AW-1:0] wreg_b_addr_i,
  input  logic [C_XLEN-1:0] wreg_b_data_i,
  output logic              exs_valid_o,
  input  logic              exs_ready_i,
  output logic [C_XLEN-1:0] exs_rs1_data_o,
  output logic [C_XLEN-1:0] exs_rs2_data_o,
  output slot_state_e       dbg_state_o
);

  slot_state_e       state_q, state_d;
  logic              use1_q, use1_d, use2_q, use2_d;
  logic [REG_AW-1:0] addr1_q, addr1_d, addr2_q, addr2_d;
  logic              byp1_hit_q, byp1_hit_d, byp2_hit_q, byp2_hit_d;
  logic [C_XLEN-1:0] byp1_data_q, byp1_data_d, byp2_data_q, byp2_data_d;
  logic [C_XLEN-1:0] hold1_q, hold1_d, hold2_q, hold2_d;

  logic              accept;
  logic              consume;
  logic [REG_AW-1:0] cmp1_addr, cmp2_addr;
  logic              snoop1_hit, snoop2_hit;
  logic [C_XLEN-1:0] snoop1_data, snoop2_data;

  // Handshake and read-port control; read addresses are plain copies.
  always_comb begin
    exs_valid_o   = (state_q != ST_IDLE);
    ids_ready_o   = clk_en_i && (!exs_valid_o || exs_ready_i);
    accept        = ids_valid_i && ids_ready_o;
    consume       = exs_valid_o && exs_ready_i && clk_en_i;
    rreg_a_rd_o   = accept && ids_rs1_rd_i;
    rreg_b_rd_o   = accept && ids_rs2_rd_i;
    rreg_a_addr_o = ids_rs1_addr_i;
    rreg_b_addr_o = ids_rs2_addr_i;
    // Accept and held-update never coincide, so one comparator per operand suffices.
    cmp1_addr     = accept ? ids_rs1_addr_i : addr1_q;
    cmp2_addr     = accept ? ids_rs2_addr_i : addr2_q;
    dbg_state_o   = state_q;
  end

  regfile_bypass #(.C_XLEN(C_XLEN)) u_byp_rs1 (
    .addr_i    (cmp1_addr),
    .wr_a_i    (wreg_a_wr_i),
    .waddr_a_i (wreg_a_addr_i),
    .wdata_a_i (wreg_a_data_i),
    .wr_b_i    (wreg_b_wr_i),
    .waddr_b_i (wreg_b_addr_i),
    .wdata_b_i (wreg_b_data_i),
    .hit_o     (snoop1_hit),
    .data_o    (snoop1_data)
  );

  regfile_bypass #(.C_XLEN(C_XLEN)) u_byp_rs2 (
    .addr_i    (cmp2_addr),
    .wr_a_i    (wreg_a_wr_i),
    .waddr_a_i (wreg_a_addr_i),
    .wdata_a_i (wreg_a_data_i),
    .wr_b_i    (wreg_b_wr_i),
    .waddr_b_i (wreg_b_addr_i),
    .wdata_b_i (wreg_b_data_i),
    .hit_o     (snoop2_hit),
    .data_o    (snoop2_data)
  );

  // Operand select: unused/x0 operands read as zero; first cycle uses captured
  // bypass or fresh read data, later cycles use the hold registers.
  always_comb begin
    exs_rs1_data_o = '0;
    exs_rs2_data_o = '0;
    if (state_q == ST_FIRST) begin
      if (use1_q) exs_rs1_data_o = byp1_hit_q ? byp1_data_q : rreg_a_data_i;
      if (use2_q) exs_rs2_data_o = byp2_hit_q ? byp2_data_q : rreg_b_data_i;
    end else if (state_q == ST_HOLD) begin
      if (use1_q) exs_rs1_data_o = hold1_q;
      if (use2_q) exs_rs2_data_o = hold2_q;
    end
  end

  // Slot next state: load on accept, drop on consume, otherwise refresh holds.
  always_comb begin
    state_d     = state_q;
    use1_d      = use1_q;
    use2_d      = use2_q;
    addr1_d     = addr1_q;
    addr2_d     = addr2_q;
    byp1_hit_d  = byp1_hit_q;
    byp2_hit_d  = byp2_hit_q;
    byp1_data_d = byp1_data_q;
    byp2_data_d = byp2_data_q;
    hold1_d     = hold1_q;
    hold2_d     = hold2_q;
    if (accept) begin
      state_d     = ST_FIRST;
      use1_d      = ids_rs1_rd_i && (ids_rs1_addr_i != '0);
      use2_d      = ids_rs2_rd_i && (ids_rs2_addr_i != '0);
      addr1_d     = ids_rs1_addr_i;
      addr2_d     = ids_rs2_addr_i;
      byp1_hit_d  = ids_rs1_rd_i && snoop1_hit;
      byp2_hit_d  = ids_rs2_rd_i && snoop2_hit;
      byp1_data_d = snoop1_data;
      byp2_data_d = snoop2_data;
    end else if (consume) begin
      state_d = ST_IDLE;
    end else if (exs_valid_o) begin
      state_d = ST_HOLD;
      hold1_d = (use1_q && snoop1_hit) ? snoop1_data : exs_rs1_data_o;
      hold2_d = (use2_q && snoop2_hit) ? snoop2_data : exs_rs2_data_o;
    end
  end

  // State registers: reset wins over clock enable; clk_en_i low freezes everything.
  always_ff @(posedge clk_i) begin
    if (!resetb_i) begin
      state_q     <= ST_IDLE;
      use1_q      <= 1'b0;
      use2_q      <= 1'b0;
      addr1_q     <= '0;
      addr2_q     <= '0;
      byp1_hit_q  <= 1'b0;
      byp2_hit_q  <= 1'b0;
      byp1_data_q <= '0;
      byp2_data_q <= '0;
      hold1_q     <= '0;
      hold2_q     <= '0;
    end else if (clk_en_i) begin
      state_q     <= state_d;
      use1_q      <= use1_d;
      use2_q      <= use2_d;
      addr1_q     <= addr1_d;
      addr2_q     <= addr2_d;
      byp1_hit_q  <= byp1_hit_d;
      byp2_hit_q  <= byp2_hit_d;
      byp1_data_q <= byp1_data_d;
      byp2_data_q <= byp2_data_d;
      hold1_q     <= hold1_d;
      hold2_q     <= hold2_d;
    end
  end

endmodule

// File: tb/tb_regfile_operand_fetch.sv
// Bench for regfile_operand_fetch: behavioural register file, scoreboard of
// expected operand pairs, and one task per scenario.
module tb_regfile_operand_fetch;
  import regfile_operand_fetch_pkg::*;

  localparam int XLEN = 32;

  typedef struct packed {
    logic            use1;
    logic [4:0]      a1;
    logic [XLEN-1:0] d1;
    logic            use2;
    logic [4:0]      a2;
    logic [XLEN-1:0] d2;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            resetb = 1'b0;
  logic            clk_en = 1'b0;
  logic            ids_valid = 1'b0;
  logic            ids_ready;
  logic            rs1_rd = 1'b0, rs2_rd = 1'b0;
  logic [4:0]      rs1_addr = '0, rs2_addr = '0;
  logic            ra_rd, rb_rd;
  logic [4:0]      ra_addr, rb_addr;
  logic [XLEN-1:0] ra_data = '0, rb_data = '0;
  logic            wa_wr = 1'b0, wb_wr = 1'b0;
  logic [4:0]      wa_addr = '0, wb_addr = '0;
  logic [XLEN-1:0] wa_data = '0, wb_data = '0;
  logic            exs_valid;
  logic            exs_ready = 1'b0;
  logic [XLEN-1:0] rs1_data, rs2_data;
  slot_state_e     dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t exp_q[$];

  regfile_operand_fetch #(.C_XLEN(XLEN)) dut (
    .clk_i          (clk),
    .resetb_i       (resetb),
    .clk_en_i       (clk_en),
    .ids_valid_i    (ids_valid),
    .ids_ready_o    (ids_ready),
    .ids_rs1_rd_i   (rs1_rd),
    .ids_rs2_rd_i   (rs2_rd),
    .ids_rs1_addr_i (rs1_addr),
    .ids_rs2_addr_i (rs2_addr),
    .rreg_a_rd_o    (ra_rd),
    .rreg_b_rd_o    (rb_rd),
    .rreg_a_addr_o  (ra_addr),
    .rreg_b_addr_o  (rb_addr),
    .rreg_a_data_i  (ra_data),
    .rreg_b_data_i  (rb_data),
    .wreg_a_wr_i    (wa_wr),
    .wreg_a_addr_i  (wa_addr),
    .wreg_a_data_i  (wa_data),
    .wreg_b_wr_i    (wb_wr),
    .wreg_b_addr_i  (wb_addr),
    .wreg_b_data_i  (wb_data),
    .exs_valid_o    (exs_valid),
    .exs_ready_i    (exs_ready),
    .exs_rs1_data_o (rs1_data),
    .exs_rs2_data_o (rs2_data),
    .dbg_state_o    (dbg_state)
  );

  // ---------------- register file model ----------------
  // Read-before-write; port b written last so it wins on a same-address write.
  logic [XLEN-1:0] rf [32] = '{default: '0};
  always @(posedge clk) begin
    if (ra_rd) ra_data <= rf[ra_addr];
    if (rb_rd) rb_data <= rf[rb_addr];
    if (clk_en && wa_wr && wa_addr != 5'd0) rf[wa_addr] <= wa_data;
    if (clk_en && wb_wr && wb_addr != 5'd0) rf[wb_addr] <= wb_data;
  end

  function automatic logic [XLEN-1:0] fetch_exp(input logic rd, input logic [4:0] a);
    if (!rd || a == 5'd0) return '0;
    if (wb_wr && wb_addr == a) return wb_data;
    if (wa_wr && wa_addr == a) return wa_data;
    return rf[a];
  endfunction

  function automatic logic [XLEN-1:0] snoop_exp(input logic u, input logic [4:0] a,
                                                input logic [XLEN-1:0] cur);
    if (!u) return cur;
    if (wb_wr && wb_addr == a) return wb_data;
    if (wa_wr && wa_addr == a) return wa_data;
    return cur;
  endfunction

  // ---------------- scoreboard ----------------
  // Sampled mid-cycle (negedge): push on accept, pop on transfer, apply
  // snooped writes to the held entry while stalled.
  always @(negedge clk) begin
    exp_t e;
    if (resetb !== 1'b1) begin
      exp_q.delete();
    end else if (clk_en) begin
      if (exs_valid && exs_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: transfer with rs1=%h rs2=%h, expected none", rs1_data, rs2_data);
        end else begin
          e = exp_q.pop_front();
          if (rs1_data !== e.d1 || rs2_data !== e.d2) begin
            n_fail++;
            $display("FAIL sb_data: got rs1=%h rs2=%h, expected rs1=%h rs2=%h",
                     rs1_data, rs2_data, e.d1, e.d2);
          end
        end
      end else if (exs_valid && exp_q.size() > 0) begin
        e = exp_q[0];
        e.d1 = snoop_exp(e.use1, e.a1, e.d1);
        e.d2 = snoop_exp(e.use2, e.a2, e.d2);
        exp_q[0] = e;
      end
      if (ids_valid && ids_ready) begin
        e.use1 = rs1_rd && rs1_addr != 5'd0;
        e.a1   = rs1_addr;
        e.d1   = fetch_exp(rs1_rd, rs1_addr);
        e.use2 = rs2_rd && rs2_addr != 5'd0;
        e.a2   = rs2_addr;
        e.d2   = fetch_exp(rs2_rd, rs2_addr);
        exp_q.push_back(e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    resetb    = 1'b1;
    clk_en    = 1'b1;
    ids_valid = 1'b0;
    rs1_rd    = 1'b0;
    rs2_rd    = 1'b0;
    rs1_addr  = '0;
    rs2_addr  = '0;
    exs_ready = 1'b1;
    wa_wr     = 1'b0;
    wb_wr     = 1'b0;
    wa_addr   = '0;
    wb_addr   = '0;
    wa_data   = '0;
    wb_data   = '0;
  endtask

  task automatic req(input logic r1, input logic [4:0] a1, input logic r2, input logic [4:0] a2);
    ids_valid = 1'b1;
    rs1_rd    = r1;
    rs1_addr  = a1;
    rs2_rd    = r2;
    rs2_addr  = a2;
  endtask

  task automatic wr(input logic we_a, input logic [4:0] aa, input logic [XLEN-1:0] da,
                    input logic we_b, input logic [4:0] ab, input logic [XLEN-1:0] db);
    wa_wr = we_a; wa_addr = aa; wa_data = da;
    wb_wr = we_b; wb_addr = ab; wb_data = db;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle();
    resetb = 1'b0;
    clk_en = 1'b0;
    tick(); tick();
    settle();
    n_checks++;
    if (exs_valid !== 1'b0 || rs1_data !== '0 || rs2_data !== '0 || ids_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b rs1=%h rs2=%h ready=%b, expected 0/0/0/0",
               exs_valid, rs1_data, rs2_data, ids_ready);
    end
    clk_en = 1'b1;
    #1;
    n_checks++;
    if (ids_ready !== 1'b1 || ra_rd !== 1'b0 || dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_ready: ready=%b ra_rd=%b state=%0d, expected 1/0/0", ids_ready, ra_rd, dbg_state);
    end
    tick();
    idle();
  endtask

  task automatic test_basic();
    tick(); idle(); wr(1, 5'd5, 32'h11, 1, 5'd6, 32'h22);
    tick(); idle(); req(1, 5'd5, 1, 5'd6);
    settle();
    n_checks++;
    if (ids_ready !== 1'b1 || ra_rd !== 1'b1 || rb_rd !== 1'b1 || ra_addr !== 5'd5 ||
        rb_addr !== 5'd6 || exs_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_accept: ready=%b rd=%b%b addr=%0d/%0d valid=%b, expected 1 11 5/6 0",
               ids_ready, ra_rd, rb_rd, ra_addr, rb_addr, exs_valid);
    end
    tick(); idle();
    settle();
    n_checks++;
    if (exs_valid !== 1'b1 || rs1_data !== 32'h11 || rs2_data !== 32'h22 || ra_rd !== 1'b0 || rb_rd !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_output: valid=%b rs1=%h rs2=%h rd=%b%b, expected 1 11 22 00",
               exs_valid, rs1_data, rs2_data, ra_rd, rb_rd);
    end
    tick(); idle();
    settle();
    n_checks++;
    if (exs_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_drain: valid=%b, expected 0", exs_valid);
    end
  endtask

  task automatic test_bypass();
    tick(); idle(); wr(1, 5'd7, 32'h01, 0, 5'd0, '0);
    tick(); idle(); req(1, 5'd7, 0, 5'd3); wr(1, 5'd7, 32'hAB, 0, 5'd0, '0);
    tick(); idle(); req(0, 5'd0, 1, 5'd7);
    settle();
    n_checks++;
    if (exs_valid !== 1'b1 || rs1_data !== 32'hAB || rs2_data !== '0) begin
      n_fail++;
      $display("FAIL bypass_accept: valid=%b rs1=%h rs2=%h, expected 1 ab 0", exs_valid, rs1_data, rs2_data);
    end
    tick(); idle();
    settle();
    n_checks++;
    if (rs2_data !== 32'hAB || rs1_data !== '0) begin
      n_fail++;
      $display("FAIL bypass_file: rs1=%h rs2=%h, expected 0 ab", rs1_data, rs2_data);
    end
  endtask

  task automatic test_x0();
    tick(); idle(); req(1, 5'd0, 1, 5'd5); wr(1, 5'd5, 32'h55, 1, 5'd0, 32'hFF);
    tick(); idle();
    settle();
    n_checks++;
    if (exs_valid !== 1'b1 || rs1_data !== '0 || rs2_data !== 32'h55) begin
      n_fail++;
      $display("FAIL x0_zero: valid=%b rs1=%h rs2=%h, expected 1 0 55", exs_valid, rs1_data, rs2_data);
    end
  endtask

  task automatic test_stall();
    tick(); idle(); wr(1, 5'd9, 32'h33, 0, 5'd0, '0);
    tick(); idle(); req(1, 5'd9, 1, 5'd5); exs_ready = 1'b0;
    tick(); idle(); exs_ready = 1'b0;
    settle();
    n_checks++;
    if (exs_valid !== 1'b1 || ids_ready !== 1'b0 || rs1_data !== 32'h33 || dbg_state !== ST_FIRST) begin
      n_fail++;
      $display("FAIL stall_c1: valid=%b ready=%b rs1=%h state=%0d, expected 1 0 33 1",
               exs_valid, ids_ready, rs1_data, dbg_state);
    end
    tick(); idle(); exs_ready = 1'b0; wr(1, 5'd9, 32'h10, 1, 5'd9, 32'h20);
    settle();
    n_checks++;
    if (ids_ready !== 1'b0 || rs1_data !== 32'h33) begin
      n_fail++;
      $display("FAIL stall_c2: ready=%b rs1=%h, expected 0 33", ids_ready, rs1_data);
    end
    tick(); idle(); exs_ready = 1'b0;
    settle();
    n_checks++;
    if (ids_ready !== 1'b0 || rs1_data !== 32'h20 || rs2_data !== 32'h55 || dbg_state !== ST_HOLD) begin
      n_fail++;
      $display("FAIL stall_c3: ready=%b rs1=%h rs2=%h state=%0d, expected 0 20 55 2",
               ids_ready, rs1_data, rs2_data, dbg_state);
    end
    // Consume while a write to the same register lands: consumed value unaffected.
    tick(); idle(); wr(1, 5'd9, 32'h77, 0, 5'd0, '0);
    settle();
    n_checks++;
    if (ids_ready !== 1'b1 || rs1_data !== 32'h20) begin
      n_fail++;
      $display("FAIL stall_consume: ready=%b rs1=%h, expected 1 20", ids_ready, rs1_data);
    end
    tick(); idle();
    settle();
    n_checks++;
    if (exs_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_drain: valid=%b, expected 0", exs_valid);
    end
  endtask

  task automatic test_back_to_back();
    exp_t f;
    for (int i = 1; i < 32; i += 2) begin
      tick(); idle();
      wr(1, 5'(i), XLEN'($urandom), (i + 1) < 32, 5'((i + 1) % 32), XLEN'($urandom));
    end
    for (int k = 0; k < 13; k++) begin
      tick(); idle();
      if (k < 12) req(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                      1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 1) == 1)
        wr(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), XLEN'($urandom),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), XLEN'($urandom));
      if (k == 5 || k == 6) clk_en = 1'b0;
      settle();
      if (clk_en) begin
        n_checks++;
        if (ids_ready !== 1'b1 || (k < 12 && (ra_rd !== rs1_rd || rb_rd !== rs2_rd))) begin
          n_fail++;
          $display("FAIL b2b_issue k=%0d: ready=%b rd=%b%b, expected 1 %b%b",
                   k, ids_ready, ra_rd, rb_rd, rs1_rd, rs2_rd);
        end
      end else begin
        n_checks++;
        if (ids_ready !== 1'b0 || ra_rd !== 1'b0 || rb_rd !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_frozen_issue k=%0d: ready=%b rd=%b%b, expected 0 00", k, ids_ready, ra_rd, rb_rd);
        end
      end
      if (k > 0) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_queue k=%0d: queue empty, expected a pending entry", k);
        end else begin
          f = exp_q[0];
          if (exs_valid !== 1'b1 || rs1_data !== f.d1 || rs2_data !== f.d2) begin
            n_fail++;
            $display("FAIL b2b_output k=%0d: valid=%b rs1=%h rs2=%h, expected 1 %h %h",
                     k, exs_valid, rs1_data, rs2_data, f.d1, f.d2);
          end
        end
      end
    end
    tick(); idle();
    settle();
    n_checks++;
    if (exs_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain: valid=%b, expected 0", exs_valid);
    end
  endtask

  task automatic test_reset_stall();
    tick(); idle(); req(1, 5'd5, 1, 5'd6); exs_ready = 1'b0;
    tick(); idle(); exs_ready = 1'b0;
    settle();
    n_checks++;
    if (exs_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_stall_hold: valid=%b, expected 1", exs_valid);
    end
    tick(); idle(); resetb = 1'b0; clk_en = 1'b0;
    tick(); idle();
    settle();
    n_checks++;
    if (exs_valid !== 1'b0 || rs1_data !== '0 || rs2_data !== '0 || dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL rst_stall_clear: valid=%b rs1=%h rs2=%h state=%0d, expected 0 0 0 0",
               exs_valid, rs1_data, rs2_data, dbg_state);
    end
    tick(); idle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_bypass();
    test_x0();
    test_stall();
    test_back_to_back();
    test_reset_stall();
    tick(); idle();
    settle();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: %0d entries pending, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
